// File: rtl/parity_rx_pkg.sv
// Shared types and constants for the serial parity receiver: FSM state
// encoding, parity-mode selectors and the bit-counter width helper.
package parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_e;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  // Wide enough to hold counts 0..data_w inclusive.
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/parity_out_slot.sv
// Single-entry valid/ready output register with overrun detection.
// Optional saturating error-frame counter under PARITY_ERR_COUNT_EN.
module parity_out_slot #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity_err,
  output logic              out_valid,
  output logic              overrun
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  logic slot_free;
  logic accept;

  // Slot can take a new word if empty or being drained this same cycle.
  assign slot_free = !out_valid || out_ready;
  assign accept    = load && slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data       <= '0;
      out_parity_err <= 1'b0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= load && !slot_free;
      if (accept) begin
        out_data       <= load_data;
        out_parity_err <= load_err;
        out_valid      <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && load_err && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/serial_parity_receiver.sv
// Serial frame deserialiser with running parity check feeding a single-entry
// valid/ready output slot. Optional error counter: PARITY_ERR_COUNT_EN.
module serial_parity_receiver
  import parity_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_abort
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int unsigned CNT_W   = cnt_width(DATA_W);
  localparam logic        ODD_BIT = (ODD_PARITY == PAR_ODD);

  rx_state_e         state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              par, par_n;
  logic              abort_n;
  logic              frame_done;
  logic              frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      par         <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      cnt         <= cnt_n;
      par         <= par_n;
      frame_abort <= abort_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    par_n      = par;
    abort_n    = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (bit_valid) begin
      if (sof) begin
        // sof always restarts; mid-frame (including the parity slot) it aborts.
        abort_n = (state != IDLE);
        shreg_n = DATA_W'(bit_in);
        cnt_n   = CNT_W'(1);
        par_n   = bit_in;
        state_n = DATA;
      end else begin
        case (state)
          IDLE: ;
          DATA: begin
            shreg_n = shreg | (DATA_W'(bit_in) << cnt);
            par_n   = par ^ bit_in;
            cnt_n   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) state_n = PARITY;
          end
          PARITY: begin
            frame_done = 1'b1;
            frame_err  = par ^ bit_in ^ ODD_BIT;
            cnt_n      = '0;
            state_n    = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  parity_out_slot #(
    .DATA_W(DATA_W)
  ) u_out_slot (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (frame_done),
    .load_data      (shreg),
    .load_err       (frame_err),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_parity_err (out_parity_err),
    .out_valid      (out_valid),
    .overrun        (overrun)
`ifdef PARITY_ERR_COUNT_EN
    ,
    .err_count      (err_count)
`endif
  );

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Bench for serial_parity_receiver: even- and odd-parity instances share
// stimulus and are checked against a queue-based frame model.
module tb_serial_parity_receiver;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_valid = 1'b0, bit_in = 1'b0, sof = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] data_e, data_o;
  logic          err_e, err_o, val_e, val_o, ovr_e, ovr_o, abt_e, abt_o;
`ifdef PARITY_ERR_COUNT_EN
  logic [15:0]   cnt_e, cnt_o;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model: bits of the open frame, plus expected output registers.
  bit            q[$];
  bit            in_frame;
  logic          m_valid, m_err_e, m_err_o, m_ovr, m_abort;
  logic [DW-1:0] m_data;
  int unsigned   m_cnt_e, m_cnt_o;

  always #5 clk = ~clk;

  serial_parity_receiver #(.DATA_W(DW), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .out_data(data_e), .out_parity_err(err_e), .out_valid(val_e), .out_ready(out_ready),
    .overrun(ovr_e), .frame_abort(abt_e)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(cnt_e)
`endif
  );

  serial_parity_receiver #(.DATA_W(DW), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .out_data(data_o), .out_parity_err(err_o), .out_valid(val_o), .out_ready(out_ready),
    .overrun(ovr_o), .frame_abort(abt_o)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(cnt_o)
`endif
  );

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    m_valid = 1'b0; m_err_e = 1'b0; m_err_o = 1'b0;
    m_ovr = 1'b0; m_abort = 1'b0; m_data = '0;
    m_cnt_e = 0; m_cnt_o = 0;
  endtask

  task automatic model_step(input logic bv, input logic s, input logic b, input logic rdy);
    bit            done = 0;
    logic [DW-1:0] w = '0;
    logic          e = 1'b0;
    m_abort = 1'b0;
    m_ovr   = 1'b0;
    if (bv) begin
      if (s) begin
        if (in_frame) m_abort = 1'b1;
        q.delete();
        q.push_back(b);
        in_frame = 1'b1;
      end else if (in_frame) begin
        if (q.size() < DW) q.push_back(b);
        else begin
          done = 1;
          foreach (q[i]) w[i] = q[i];
          e = ((($countones(w) + int'(b)) % 2) == 1);
          in_frame = 1'b0;
          q.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1; m_data = w; m_err_e = e; m_err_o = !e;
        if (e && m_cnt_e < 65535) m_cnt_e++;
        if (!e && m_cnt_o < 65535) m_cnt_o++;
      end else m_ovr = 1'b1;
    end else if (m_valid && rdy) m_valid = 1'b0;
  endtask

  task automatic step(input logic bv, input logic s, input logic b, input logic rdy);
    bit_valid = bv; sof = s; bit_in = b; out_ready = rdy;
    model_step(bv, s, b, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [DW-1:0] d, input int n, input bit first_sof,
                           input bit gap, input logic rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b1, first_sof && (i == 0), d[i], rdy);
      if (gap) step(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input bit gap,
                            input logic rdy, input logic rdy_last);
    send_bits(d, DW, 1, gap, rdy);
    step(1'b1, 1'b0, par, rdy_last);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({val_e, data_e, err_e, ovr_e, abt_e} !== '0) begin
      fails++;
      $display("FAIL reset_even: got %b expected 0", {val_e, data_e, err_e, ovr_e, abt_e});
    end
    checks++;
    if ({val_o, data_o, err_o, ovr_o, abt_o} !== '0) begin
      fails++;
      $display("FAIL reset_odd: got %b expected 0", {val_o, data_o, err_o, ovr_o, abt_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 0, 1'b1, 1'b1);
    checks++;
    if ({val_e, data_e, err_e} !== {1'b1, 8'hA5, 1'b0}) begin
      fails++;
      $display("FAIL basic_even_ok: got v=%b d=%h e=%b expected v=1 d=a5 e=0", val_e, data_e, err_e);
    end
    checks++;
    if (err_o !== 1'b1) begin
      fails++;
      $display("FAIL basic_odd_bad: got %b expected 1", err_o);
    end
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b1);
    checks++;
    if ({val_e, data_e, err_e} !== {1'b1, 8'hA5, 1'b1}) begin
      fails++;
      $display("FAIL basic_even_bad: got v=%b d=%h e=%b expected v=1 d=a5 e=1", val_e, data_e, err_e);
    end
    checks++;
    if ({val_o, err_o} !== 2'b10) begin
      fails++;
      $display("FAIL basic_odd_ok: got v=%b e=%b expected v=1 e=0", val_o, err_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (val_e !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain: got %b expected 0", val_e);
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if ({val_e, data_e, ovr_e} !== {1'b1, 8'h3C, 1'b0}) begin
      fails++;
      $display("FAIL ovr_first: got v=%b d=%h o=%b expected v=1 d=3c o=0", val_e, data_e, ovr_e);
    end
    send_frame(8'h0F, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if ({ovr_e, data_e, ovr_o} !== {1'b1, 8'h3C, 1'b1}) begin
      fails++;
      $display("FAIL ovr_pulse: got o=%b d=%h oo=%b expected o=1 d=3c oo=1", ovr_e, data_e, ovr_o);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({ovr_e, val_e, data_e} !== {1'b0, 1'b1, 8'h3C}) begin
      fails++;
      $display("FAIL ovr_hold: got o=%b v=%b d=%h expected o=0 v=1 d=3c", ovr_e, val_e, data_e);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (val_e !== 1'b0) begin
      fails++;
      $display("FAIL ovr_handshake: got %b expected 0", val_e);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h81, 1'b0, 1, 1'b0, 1'b0);
    checks++;
    if ({val_e, data_e, err_e} !== {1'b1, 8'h81, 1'b0}) begin
      fails++;
      $display("FAIL gap_frame: got v=%b d=%h e=%b expected v=1 d=81 e=0", val_e, data_e, err_e);
    end
    send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b1);
    checks++;
    if ({val_e, data_e, ovr_e} !== {1'b1, 8'h5A, 1'b0}) begin
      fails++;
      $display("FAIL b2b_load: got v=%b d=%h o=%b expected v=1 d=5a o=0", val_e, data_e, ovr_e);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    send_bits(8'h1F, 5, 1, 0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({abt_e, abt_o} !== 2'b11) begin
      fails++;
      $display("FAIL abort_pulse: got %b expected 11", {abt_e, abt_o});
    end
    send_bits(8'hFF, DW - 1, 0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({val_e, data_e, err_e, abt_e} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_next: got v=%b d=%h e=%b a=%b expected v=1 d=ff e=0 a=0",
               val_e, data_e, err_e, abt_e);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    send_frame(8'hC3, 1'b0, 0, 1'b0, 1'b0);
    send_bits(8'h77, 4, 1, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({val_e, data_e, err_e, ovr_e, abt_e} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got %b expected 0", {val_e, data_e, err_e, ovr_e, abt_e});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h96, 1'b0, 0, 1'b1, 1'b1);
    checks++;
    if ({val_e, data_e, err_e} !== {1'b1, 8'h96, 1'b0}) begin
      fails++;
      $display("FAIL post_reset: got v=%b d=%h e=%b expected v=1 d=96 e=0", val_e, data_e, err_e);
    end
  endtask

`ifdef PARITY_ERR_COUNT_EN
  task automatic test_err_count();
    send_frame(8'h01, 1'b0, 0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 0, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cnt_e !== 16'd3) begin
      fails++;
      $display("FAIL err_count_even: got %0d expected 3", cnt_e);
    end
    checks++;
    if (cnt_o !== 16'(m_cnt_o)) begin
      fails++;
      $display("FAIL err_count_odd: got %0d expected %0d", cnt_o, m_cnt_o);
    end
  endtask
`endif

  task automatic test_random();
    logic bv, s, b, rdy;
    for (int n = 0; n < 800; n++) begin
      bv  = ($urandom_range(0, 3) != 0);
      s   = bv && (in_frame ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 0));
      b   = $urandom_range(0, 1);
      rdy = $urandom_range(0, 1);
      step(bv, s, b, rdy);
      checks++;
      if ({val_e, data_e, err_e, ovr_e, abt_e} !== {m_valid, m_data, m_err_e, m_ovr, m_abort}) begin
        fails++;
        $display("FAIL rand_even cyc %0d: got %b expected %b", n,
                 {val_e, data_e, err_e, ovr_e, abt_e}, {m_valid, m_data, m_err_e, m_ovr, m_abort});
      end
      checks++;
      if ({val_o, data_o, err_o, ovr_o, abt_o} !== {m_valid, m_data, m_err_o, m_ovr, m_abort}) begin
        fails++;
        $display("FAIL rand_odd cyc %0d: got %b expected %b", n,
                 {val_o, data_o, err_o, ovr_o, abt_o}, {m_valid, m_data, m_err_o, m_ovr, m_abort});
      end
`ifdef PARITY_ERR_COUNT_EN
      checks++;
      if ({cnt_e, cnt_o} !== {16'(m_cnt_e), 16'(m_cnt_o)}) begin
        fails++;
        $display("FAIL rand_count cyc %0d: got %0d/%0d expected %0d/%0d", n,
                 cnt_e, cnt_o, m_cnt_e, m_cnt_o);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef PARITY_ERR_COUNT_EN
    test_err_count();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_parity_receiver.md
Name: serial_parity_receiver

Overview:
- Upstream deserialising stage of the parity generator/error-checker path.
- Collects a serial frame of DATA_W data bits followed by one parity bit.
- Computes running parity in flight and presents the parallel word plus an error flag on a single-entry valid/ready output register.
- Replaces the combinational checker's need for pre-assembled parallel data + parity_in.

Parameters:
- DATA_W, 8, data bits per frame (>=2).
- ODD_PARITY, 0, 0 = even-parity check; 1 = odd-parity check.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data/parity bit.
- sof  input  1  start of frame; qualified by bit_valid, marks the first data bit.
- out_data  output  DATA_W  received word; first received bit = LSB.
- out_parity_err  output  1  1 = parity mismatch for out_data.
- out_valid  output  1  out_data/out_parity_err valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- overrun  output  1  one-cycle pulse: completed frame dropped because the output register was full.
- frame_abort  output  1  one-cycle pulse: sof seen mid-frame, partial frame discarded.

Behaviour:
- Reset (async assert, sync-release usage): state = IDLE, shift register = 0, bit count = 0, running parity = 0.
- All outputs reset to 0: out_data, out_parity_err, out_valid, overrun, frame_abort.
- Only cycles with bit_valid=1 advance the FSM; cycles with bit_valid=0 hold all state.
- FSM states: IDLE, DATA, PARITY.
  - IDLE: bit_valid & sof -> store bit as bit 0, parity = bit_in, count = 1, go to DATA. bit_valid & !sof -> bit ignored.
  - DATA: each valid bit -> shift in at index count, parity ^= bit_in, count++. When the DATA_W-th bit is taken -> go to PARITY.
  - PARITY: next valid bit is the parity bit. err = parity ^ bit_in ^ ODD_PARITY. Go to IDLE; frame complete.
- sof on a valid bit in DATA or PARITY: pulse frame_abort, discard the partial frame, treat the bit as first data bit of a new frame (go to DATA, count = 1).
- sof on the parity-bit cycle counts as an abort; no output is produced.
- Output register is single-entry.
  - On frame complete with output slot free (out_valid=0, or out_valid & out_ready that same cycle): load out_data/out_parity_err and set out_valid the next cycle. Latency = 1 cycle after the parity bit.
  - On frame complete with out_valid=1 & out_ready=0: keep the old contents, drop the new frame, pulse overrun.
  - out_valid clears the cycle after handshake unless a new frame loads simultaneously.
  - out_data/out_parity_err stable while out_valid & !out_ready.
- Receiver continues accepting bits regardless of output backpressure (no stall on bit_in).
- Reset mid-frame: partial frame and any pending output lost; outputs return to reset values immediately.

Optional Feature:
- Macro: PARITY_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [15:0], reset 0.
  - Increments by 1 on each frame loaded into the output register with err=1; saturates at 16'hFFFF.
  - Dropped (overrun) and aborted frames are not counted.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package parity_rx_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY).
  - Parity-mode constants PAR_EVEN=0 and PAR_ODD=1.
  - Counter width function clog2-based for DATA_W.
- One natural sub-module, parity_out_slot: the single-entry valid/ready holding register with overrun detection. FSM/shifter stays in the top.

Test Plan (DATA_W=8):
- ODD_PARITY=0: sof + bits of 0xA5 LSB-first, then parity 0 -> one cycle later out_valid=1, out_data=0xA5, out_parity_err=0.
- Same frame with parity 1 -> out_parity_err=1. With ODD_PARITY=1 and parity 1 -> err=0.
- out_ready=0 holding frame 0x3C; second frame 0x0F completes -> overrun pulses 1 cycle; out_data stays 0x3C. Then out_ready=1 -> handshake, out_valid=0 next cycle.
- Valid/handshake interleave: bit_valid toggled 1/0 each cycle over frame 0x81 -> same result as the contiguous case (0x81, err 0). Complete a frame on the handshake cycle -> new word loads, no overrun.
- sof asserted at data bit 5 of a frame -> frame_abort pulse; subsequent 8 bits 0xFF + parity 0 -> out_data=0xFF, err=0.
- rst_n low mid-frame and with out_valid=1 -> all outputs 0 immediately. First post-reset frame decodes correctly. With PARITY_ERR_COUNT_EN: 3 error frames -> err_count=3.
